// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: shares one UART transmitter between two byte-stream sources,
// granting round-robin per packet so bytes of different packets never interleave.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   arbitration enable (checked only between packets)
//   srcN_valid/byte/last source N byte offer (held until srcN_ack), last-of-packet flag
//   srcN_ack             1-cycle accept pulse to source N
//   is_transmitting      UART sender busy
//   tx_byte, transmit    byte and 1-cycle strobe to the UART sender
//   grant                one-hot current owner (00 = none)
//   pkt_err              sticky, set when a packet exceeds MAX_PKT_LEN without a last flag
module tx_packet_arbiter #(
  parameter int MAX_PKT_LEN  = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       src0_valid,
  input  logic [7:0] src0_byte,
  input  logic       src0_last,
  output logic       src0_ack,
  input  logic       src1_valid,
  input  logic [7:0] src1_byte,
  input  logic       src1_last,
  output logic       src1_ack,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic [1:0] grant,
  output logic       pkt_err
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_RISE, WAIT_FALL} state_t;

  state_t        state;
  logic          owner;       // 0 = src0, 1 = src1
  logic          last_owner;  // owner of the most recently completed packet
  logic          last_q;      // last flag of the byte currently in flight
  logic [CW-1:0] count;       // bytes sent in the current packet, saturating
  logic [TW-1:0] timer;       // cycles spent waiting for is_transmitting to rise

  // Selected view of the current owner's inputs; the other source is ignored.
  logic       own_valid;
  logic [7:0] own_byte;
  logic       own_last;
  assign own_valid = owner ? src1_valid : src0_valid;
  assign own_byte  = owner ? src1_byte  : src0_byte;
  assign own_last  = owner ? src1_last  : src0_last;

  // Round-robin pick: on a tie the source that did not own the last packet wins.
  logic pick;
  assign pick = (src0_valid && src1_valid) ? ~last_owner : src1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      last_q     <= 1'b0;
      count      <= '0;
      timer      <= '0;
      tx_byte    <= 8'h00;
      transmit   <= 1'b0;
      src0_ack   <= 1'b0;
      src1_ack   <= 1'b0;
      grant      <= 2'b00;
      pkt_err    <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle unless re-set.
      transmit <= 1'b0;
      src0_ack <= 1'b0;
      src1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (en && !is_transmitting && (src0_valid || src1_valid)) begin
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
            count <= '0;
            state <= LOAD;
          end else begin
            grant <= 2'b00;
          end
        end
        LOAD: begin
          // A stalled owner keeps the grant indefinitely; the packet stays atomic.
          if (own_valid) begin
            tx_byte  <= own_byte;
            transmit <= 1'b1;
            if (owner) src1_ack <= 1'b1;
            else       src0_ack <= 1'b1;
            last_q   <= own_last;
            if (count != MAX_CNT) count <= count + 1'b1;
            timer    <= '0;
            state    <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          // The timeout keeps a silent UART from hanging the arbiter.
          if (is_transmitting || timer == TMO_LAST) state <= WAIT_FALL;
          else                                      timer <= timer + 1'b1;
        end
        WAIT_FALL: begin
          if (!is_transmitting) begin
            if (last_q || count == MAX_CNT) begin
              state      <= IDLE;
              last_owner <= owner;
              grant      <= 2'b00;
              if (!last_q) pkt_err <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Testbench for tx_packet_arbiter: directed packets from two source models, a simple
// UART busy model, and a monitor logging every transmit with its grant and cycle.
module tb_tx_packet_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       src0_valid, src0_last, src0_ack;
  logic [7:0] src0_byte;
  logic       src1_valid, src1_last, src1_ack;
  logic [7:0] src1_byte;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [1:0] grant;
  logic       pkt_err;

  always #5 clk = ~clk;

  tx_packet_arbiter #(.MAX_PKT_LEN(16), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src0_valid(src0_valid), .src0_byte(src0_byte), .src0_last(src0_last), .src0_ack(src0_ack),
    .src1_valid(src1_valid), .src1_byte(src1_byte), .src1_last(src1_last), .src1_ack(src1_ack),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .grant(grant), .pkt_err(pkt_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Source queues hold {last, byte}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       uart_on;
  int         cyc = 0;
  int         rise_cyc0 = 0;

  logic [7:0] log_byte[$];
  logic [1:0] log_gnt[$];
  int         log_cyc[$];
  int         ack_cnt0 = 0;
  int         ack_cnt1 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source models: consume on ack, present the next queued byte, all at negedge.
  initial begin
    src0_valid = 0; src0_byte = 0; src0_last = 0;
    src1_valid = 0; src1_byte = 0; src1_last = 0;
    forever begin
      @(negedge clk);
      if (src0_ack && q0.size() > 0) void'(q0.pop_front());
      if (src1_ack && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        if (!src0_valid) rise_cyc0 = cyc;
        src0_valid = 1'b1;
        {src0_last, src0_byte} = q0[0];
      end else begin
        src0_valid = 1'b0; src0_last = 1'b0; src0_byte = 8'h00;
      end
      if (q1.size() > 0) begin
        src1_valid = 1'b1;
        {src1_last, src1_byte} = q1[0];
      end else begin
        src1_valid = 1'b0; src1_last = 1'b0; src1_byte = 8'h00;
      end
    end
  end

  // UART model: busy for 4 cycles after each transmit, or never when uart_on is low.
  initial begin
    int uart_cnt;
    uart_cnt = 0;
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit && uart_on) uart_cnt = 4;
      else if (uart_cnt > 0)   uart_cnt--;
      is_transmitting = (uart_cnt > 0);
    end
  end

  // Monitor: log transmits, check ack pairing and strobe spacing.
  initial begin
    logic prev_tx;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (src0_ack) ack_cnt0++;
      if (src1_ack) ack_cnt1++;
      if (transmit) begin
        log_byte.push_back(tx_byte);
        log_gnt.push_back(grant);
        log_cyc.push_back(cyc);
        check_val("ack_matches_grant", {30'd0, src1_ack, src0_ack}, {30'd0, grant});
        check_val("tx_back_to_back", prev_tx, 1'b0);
      end else if (src0_ack || src1_ack) begin
        check_val("stray_ack", {src1_ack, src0_ack}, 2'b00);
      end
      prev_tx = transmit;
    end
  end

  task automatic clear_log();
    log_byte.delete();
    log_gnt.delete();
    log_cyc.delete();
    ack_cnt0 = 0;
    ack_cnt1 = 0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_byte.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_val(tag, log_byte.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while ((grant != 2'b00 || is_transmitting) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val(tag, grant, 2'b00);
  endtask

  task automatic check_entry(input int idx, input logic [7:0] b, input logic [1:0] g, input string tag);
    check_val(tag, log_byte[idx], b);
    check_val(tag, log_gnt[idx], g);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    uart_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_transmit", transmit, 1'b0);
    check_val("rst_pkt_err", pkt_err, 1'b0);
    check_val("rst_tx_byte", tx_byte, 8'h00);
    check_val("rst_acks", {src1_ack, src0_ack}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a packet, while waiting for the UART to finish.
    clear_log();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    wait_tx(1, 100, "mid_first_tx");
    check_val("mid_grant_before", grant, 2'b01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_grant", grant, 2'b00);
    check_val("mid_rst_transmit", transmit, 1'b0);
    check_val("mid_rst_pkt_err", pkt_err, 1'b0);
    check_val("mid_rst_tx_byte", tx_byte, 8'h00);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(50, "mid_idle_after");
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_no_more_tx", log_byte.size(), 1);

    // Both sources busy with 2-byte packets: strict alternation starting with src0.
    clear_log();
    for (int p = 0; p < 3; p++) begin
      q0.push_back({1'b0, 8'(8'h01 + 2*p)}); q0.push_back({1'b1, 8'(8'h02 + 2*p)});
      q1.push_back({1'b0, 8'(8'h81 + 2*p)}); q1.push_back({1'b1, 8'(8'h82 + 2*p)});
    end
    wait_tx(12, 1000, "rr_count");
    wait_idle(100, "rr_idle");
    for (int p = 0; p < 3; p++) begin
      check_entry(4*p + 0, 8'(8'h01 + 2*p), 2'b01, "rr_src0_a");
      check_entry(4*p + 1, 8'(8'h02 + 2*p), 2'b01, "rr_src0_b");
      check_entry(4*p + 2, 8'(8'h81 + 2*p), 2'b10, "rr_src1_a");
      check_entry(4*p + 3, 8'(8'h82 + 2*p), 2'b10, "rr_src1_b");
    end

    // src0 alone: 14-byte packet ending in 0xAA.
    clear_log();
    for (int i = 0; i < 13; i++) q0.push_back({1'b0, 8'(8'h55 + i)});
    q0.push_back({1'b1, 8'hAA});
    wait_tx(14, 1000, "p14_count");
    check_val("p14_latency", log_cyc[0] - rise_cyc0, 2);
    wait_idle(100, "p14_grant_after");
    for (int i = 0; i < 13; i++) check_entry(i, 8'(8'h55 + i), 2'b01, "p14_byte");
    check_entry(13, 8'hAA, 2'b01, "p14_last");
    check_val("p14_src0_acks", ack_cnt0, 14);
    check_val("p14_src1_acks", ack_cnt1, 0);
    check_val("p14_pkt_err", pkt_err, 1'b0);

    // src1 overruns MAX_PKT_LEN; forced release, then src0 wins, then src1 resumes.
    clear_log();
    for (int i = 0; i < 16; i++) q1.push_back({1'b0, 8'(8'h90 + i)});
    q1.push_back({1'b1, 8'hA0});
    q0.push_back({1'b1, 8'h77});
    wait_tx(18, 2000, "ovf_count");
    wait_idle(100, "ovf_idle");
    for (int i = 0; i < 16; i++) check_entry(i, 8'(8'h90 + i), 2'b10, "ovf_src1");
    check_entry(16, 8'h77, 2'b01, "ovf_src0_next");
    check_entry(17, 8'hA0, 2'b10, "ovf_src1_tail");
    check_val("ovf_pkt_err", pkt_err, 1'b1);

    // Silent UART: each byte advances after the busy timeout.
    clear_log();
    uart_on = 1'b0;
    q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b0, 8'hC2}); q0.push_back({1'b1, 8'hC3});
    wait_tx(3, 200, "tmo_count");
    wait_idle(100, "tmo_idle");
    check_val("tmo_gap1", log_cyc[1] - log_cyc[0], 10);
    check_val("tmo_gap2", log_cyc[2] - log_cyc[1], 10);
    check_entry(2, 8'hC3, 2'b01, "tmo_last");
    uart_on = 1'b1;

    // en drops during byte 3 of 5: packet completes, then nothing until en returns.
    clear_log();
    for (int i = 0; i < 4; i++) q0.push_back({1'b0, 8'(8'hD1 + i)});
    q0.push_back({1'b1, 8'hD5});
    wait_tx(3, 200, "en_third");
    en = 1'b0;
    q1.push_back({1'b1, 8'hE1});
    wait_tx(5, 200, "en_finish");
    wait_idle(100, "en_idle");
    repeat (40) @(posedge clk);
    #1;
    check_val("en_held_count", log_byte.size(), 5);
    check_val("en_held_grant", grant, 2'b00);
    check_entry(3, 8'hD4, 2'b01, "en_byte4");
    check_entry(4, 8'hD5, 2'b01, "en_byte5");
    en = 1'b1;
    wait_tx(6, 200, "en_resume");
    check_entry(5, 8'hE1, 2'b10, "en_src1");
    wait_idle(100, "en_final_idle");
    check_val("final_pkt_err_sticky", pkt_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
